eth_10g_tx_scheduler: RTL and testbench

//  Arbitrates the single 10G MAC TX framer between three frame sources: ARP reply, ARP request and UDP data.
//  ARP reply is triggered by the receive-side arp_op pulse. ARP request is retried periodically while the peer MAC is unresolved.
//  UDP data is eligible once the payload FIFO holds a full frame.

---
 rtl/eth_10g_tx_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_eth_10g_tx_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_10g_tx_scheduler.sv
// eth_10g_tx_scheduler
// Arbitrates the single 10G MAC TX framer between ARP reply, ARP request and
// UDP data sources. One start pulse is issued per frame. Completion is tracked
// with a timeout, and a fixed inter-frame gap follows every frame.
//
// Ports
//   clk_156_25    MAC/PHY clock
//   rst_n         asynchronous active-low reset
//   arp_op        1-cycle pulse: ARP request received, a reply is required
//   arp_resolved  level: peer MAC known (low enables periodic ARP requests)
//   udp_en        level: UDP transmission enabled
//   fifo_usedw    UDP payload FIFO fill level in 64-bit words
//   tx_ready      framer idle and able to accept a start
//   tx_done       1-cycle pulse: framer finished the current frame
//   tx_start      1-cycle start pulse to the framer
//   tx_sel        frame type: 00 none, 01 ARP reply, 10 ARP request, 11 UDP
//   tx_busy       high whenever the scheduler is not idle
//   tx_timeout    1-cycle pulse: frame abandoned without tx_done
//   udp_frame_cnt completed UDP frames (wrapping)
module eth_10g_tx_scheduler #(
  parameter int unsigned UDP_WORDS  = 183,
  parameter int unsigned FIFO_AW    = 11,
  parameter int unsigned IFG_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned ARP_RETRY  = 156250000
) (
  input  logic               clk_156_25,
  input  logic               rst_n,
  input  logic               arp_op,
  input  logic               arp_resolved,
  input  logic               udp_en,
  input  logic [FIFO_AW-1:0] fifo_usedw,
  input  logic               tx_ready,
  input  logic               tx_done,
  output logic               tx_start,
  output logic [1:0]         tx_sel,
  output logic               tx_busy,
  output logic               tx_timeout,
  output logic [15:0]        udp_frame_cnt
);

  localparam int unsigned RtW  = (ARP_RETRY > 1) ? $clog2(ARP_RETRY) : 1;
  localparam int unsigned ToW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned IfgW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [RtW-1:0]  RetryLoad = RtW'(ARP_RETRY - 1);
  localparam logic [ToW-1:0]  ToLast    = ToW'(TIMEOUT - 1);
  localparam logic [IfgW-1:0] IfgLast   = IfgW'(IFG_CYCLES - 1);

  localparam logic [1:0] SelNone = 2'b00;
  localparam logic [1:0] SelRep  = 2'b01;
  localparam logic [1:0] SelReq  = 2'b10;
  localparam logic [1:0] SelUdp  = 2'b11;

  typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_e;

  state_e          state_q, state_d;
  logic            rep_pend_q, rep_pend_d;
  logic            req_pend_q, req_pend_d;
  logic [RtW-1:0]  retry_q, retry_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [IfgW-1:0] ifg_cnt_q, ifg_cnt_d;
  logic            tx_start_q, tx_start_d;
  logic [1:0]      tx_sel_q, tx_sel_d;
  logic            tx_busy_q, tx_busy_d;
  logic            tx_timeout_q, tx_timeout_d;
  logic [15:0]     udp_cnt_q, udp_cnt_d;

  logic udp_elig;
  logic rep_clr, req_clr, req_set;

  // Unsigned compare at 32 bits so any FIFO_AW works against the threshold.
  assign udp_elig = udp_en && (32'(fifo_usedw) >= UDP_WORDS);

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    to_cnt_d     = to_cnt_q;
    ifg_cnt_d    = ifg_cnt_q;
    tx_start_d   = 1'b0;
    tx_sel_d     = tx_sel_q;
    tx_timeout_d = 1'b0;
    udp_cnt_d    = udp_cnt_q;
    rep_clr      = 1'b0;
    req_clr      = 1'b0;
    req_set      = 1'b0;

    // Periodic ARP request timer: pends immediately on 0, then every ARP_RETRY.
    if (!arp_resolved) begin
      if (retry_q == '0) begin
        retry_d = RetryLoad;
        req_set = 1'b1;
      end else begin
        retry_d = retry_q - 1'b1;
      end
    end else begin
      retry_d = '0;
    end

    case (state_q)
      StIdle: begin
        if (tx_ready && (rep_pend_q || req_pend_q || udp_elig)) begin
          state_d    = StStart;
          tx_start_d = 1'b1;
          if (rep_pend_q) begin
            tx_sel_d = SelRep;
            rep_clr  = 1'b1;
          end else if (req_pend_q) begin
            tx_sel_d = SelReq;
            req_clr  = 1'b1;
          end else begin
            tx_sel_d = SelUdp;
          end
        end
      end
      StStart: begin
        state_d  = StWait;
        to_cnt_d = '0;
      end
      StWait: begin
        // Done wins over a coincident expiry.
        if (tx_done) begin
          state_d   = StGap;
          ifg_cnt_d = '0;
          tx_sel_d  = SelNone;
          if (tx_sel_q == SelUdp) begin
            udp_cnt_d = udp_cnt_q + 16'd1;
          end
        end else if (to_cnt_q == ToLast) begin
          state_d      = StGap;
          ifg_cnt_d    = '0;
          tx_sel_d     = SelNone;
          tx_timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (ifg_cnt_q == IfgLast) begin
          state_d = StIdle;
        end else begin
          ifg_cnt_d = ifg_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new arp_op on the grant cycle keeps the reply pending (set wins).
    rep_pend_d = arp_op | (rep_pend_q & ~rep_clr);
    req_pend_d = arp_resolved ? 1'b0 : (req_set | (req_pend_q & ~req_clr));
    tx_busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk_156_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rep_pend_q   <= 1'b0;
      req_pend_q   <= 1'b0;
      retry_q      <= '0;
      to_cnt_q     <= '0;
      ifg_cnt_q    <= '0;
      tx_start_q   <= 1'b0;
      tx_sel_q     <= SelNone;
      tx_busy_q    <= 1'b0;
      tx_timeout_q <= 1'b0;
      udp_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rep_pend_q   <= rep_pend_d;
      req_pend_q   <= req_pend_d;
      retry_q      <= retry_d;
      to_cnt_q     <= to_cnt_d;
      ifg_cnt_q    <= ifg_cnt_d;
      tx_start_q   <= tx_start_d;
      tx_sel_q     <= tx_sel_d;
      tx_busy_q    <= tx_busy_d;
      tx_timeout_q <= tx_timeout_d;
      udp_cnt_q    <= udp_cnt_d;
    end
  end

  assign tx_start      = tx_start_q;
  assign tx_sel        = tx_sel_q;
  assign tx_busy       = tx_busy_q;
  assign tx_timeout    = tx_timeout_q;
  assign udp_frame_cnt = udp_cnt_q;

endmodule

// File: tb/tb_eth_10g_tx_scheduler.sv
// Directed testbench for eth_10g_tx_scheduler with ARP_RETRY=100, TIMEOUT=16.
module tb_eth_10g_tx_scheduler;

  logic        clk_156_25;
  logic        rst_n;
  logic        arp_op;
  logic        arp_resolved;
  logic        udp_en;
  logic [10:0] fifo_usedw;
  logic        tx_ready;
  logic        tx_done;
  logic        tx_start;
  logic [1:0]  tx_sel;
  logic        tx_busy;
  logic        tx_timeout;
  logic [15:0] udp_frame_cnt;

  int vectors;
  int miscompares;
  int cyc;

  eth_10g_tx_scheduler #(
    .UDP_WORDS (183),
    .FIFO_AW   (11),
    .IFG_CYCLES(2),
    .TIMEOUT   (16),
    .ARP_RETRY (100)
  ) dut (
    .clk_156_25   (clk_156_25),
    .rst_n        (rst_n),
    .arp_op       (arp_op),
    .arp_resolved (arp_resolved),
    .udp_en       (udp_en),
    .fifo_usedw   (fifo_usedw),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done),
    .tx_start     (tx_start),
    .tx_sel       (tx_sel),
    .tx_busy      (tx_busy),
    .tx_timeout   (tx_timeout),
    .udp_frame_cnt(udp_frame_cnt)
  );

  initial clk_156_25 = 1'b0;
  always #5 clk_156_25 = ~clk_156_25;

  // Advance one clock; outputs are read and inputs driven 1 ns after the edge.
  task automatic step();
    @(posedge clk_156_25);
    #1;
    cyc++;
  endtask

  // Runs n cycles answering every start with tx_done in its first WAIT cycle.
  task automatic run_frames(input int n, output int nstart, output int nrep);
    bit arm;
    arm    = 1'b0;
    nstart = 0;
    nrep   = 0;
    for (int i = 0; i < n; i++) begin
      step();
      tx_done = 1'b0;
      if (arm) begin
        tx_done = 1'b1;
        arm     = 1'b0;
      end
      if (tx_start === 1'b1) begin
        nstart++;
        if (tx_sel === 2'b01) nrep++;
        arm = 1'b1;
      end
    end
    step();
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b1;
    arp_op       = 1'b0;
    arp_resolved = 1'b0;
    udp_en       = 1'b0;
    fifo_usedw   = '0;
    tx_ready     = 1'b1;
    tx_done      = 1'b0;
    #2 rst_n = 1'b0;
    step();
    step();
    step();
    vectors++;
    if ({tx_start, tx_sel, tx_busy, tx_timeout, udp_frame_cnt} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got start=%b sel=%b busy=%b to=%b cnt=%0d, want all 0",
               tx_start, tx_sel, tx_busy, tx_timeout, udp_frame_cnt);
    end
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_arp_request();
    step();
    step();
    vectors++;
    if (tx_start !== 1'b1 || tx_sel !== 2'b10) begin
      miscompares++;
      $display("FAIL t1_first_req: cycle 2 got start=%b sel=%b, want start=1 sel=10",
               tx_start, tx_sel);
    end
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    vectors++;
    if (tx_start !== 1'b0 || tx_sel !== 2'b00 || tx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL t1_gap: got start=%b sel=%b busy=%b, want start=0 sel=00 busy=1",
               tx_start, tx_sel, tx_busy);
    end
    for (int i = 0; i < 300 && tx_start !== 1'b1; i++) step();
    // Pend at cycle 1, next pend 100 cycles later at 101, start at 102.
    vectors++;
    if (cyc != 102 || tx_sel !== 2'b10) begin
      miscompares++;
      $display("FAIL t1_retry: got start at cycle %0d sel=%b, want cycle 102 sel=10",
               cyc, tx_sel);
    end
    arp_resolved = 1'b1;
    step();
    vectors++;
    if (tx_sel !== 2'b10 || tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL t1_wait_sel: got sel=%b start=%b, want sel=10 start=0", tx_sel, tx_start);
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL t1_idle: got busy=%b, want 0", tx_busy);
    end
  endtask

  task automatic test_reply_then_udp();
    int c;
    fifo_usedw = 11'd200;
    c = cyc;
    arp_op = 1'b1;
    step();
    arp_op = 1'b0;
    udp_en = 1'b1;
    step();
    vectors++;
    if (tx_start !== 1'b1 || tx_sel !== 2'b01) begin
      miscompares++;
      $display("FAIL t2_reply: cycle n+2 got start=%b sel=%b, want start=1 sel=01",
               tx_start, tx_sel);
    end
    while (cyc < c + 12) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    vectors++;
    if (tx_sel !== 2'b00 || tx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL t2_gap: got sel=%b busy=%b, want sel=00 busy=1", tx_sel, tx_busy);
    end
    for (int i = 0; i < 20 && tx_start !== 1'b1; i++) step();
    vectors++;
    if (cyc != c + 16 || tx_sel !== 2'b11) begin
      miscompares++;
      $display("FAIL t2_udp_start: got cycle n+%0d sel=%b, want cycle n+16 sel=11",
               cyc - c, tx_sel);
    end
    udp_en = 1'b0;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    vectors++;
    if (udp_frame_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL t2_udp_count: got %0d, want 1", udp_frame_cnt);
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_udp_threshold();
    int c;
    bit seen;
    seen       = 1'b0;
    fifo_usedw = 11'd182;
    udp_en     = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tx_start === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL t3_below: got tx_start with fifo_usedw=182, want none");
    end
    fifo_usedw = 11'd183;
    c = cyc;
    for (int i = 0; i < 10 && tx_start !== 1'b1; i++) step();
    vectors++;
    if (cyc - c < 1 || cyc - c > 2 || tx_sel !== 2'b11) begin
      miscompares++;
      $display("FAIL t3_at_threshold: got start after %0d cycles sel=%b, want <=2 sel=11",
               cyc - c, tx_sel);
    end
    udp_en = 1'b0;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    vectors++;
    if (udp_frame_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL t3_udp_count: got %0d, want 2", udp_frame_cnt);
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_timeout();
    int s;
    fifo_usedw = 11'd200;
    udp_en     = 1'b1;
    for (int i = 0; i < 10 && tx_start !== 1'b1; i++) step();
    s      = cyc;
    udp_en = 1'b0;
    // WAIT starts at s+1; the pulse lands 16 cycles later.
    while (cyc < s + 16) step();
    vectors++;
    if (tx_sel !== 2'b11 || tx_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL t4_last_wait: got sel=%b timeout=%b, want sel=11 timeout=0",
               tx_sel, tx_timeout);
    end
    step();
    vectors++;
    if (tx_timeout !== 1'b1 || tx_sel !== 2'b00 || tx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL t4_pulse: got timeout=%b sel=%b busy=%b, want timeout=1 sel=00 busy=1",
               tx_timeout, tx_sel, tx_busy);
    end
    step();
    vectors++;
    if (tx_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL t4_pulse_width: got timeout=%b, want 0", tx_timeout);
    end
    step();
    vectors++;
    if (tx_busy !== 1'b0 || udp_frame_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL t4_after: got busy=%b cnt=%0d, want busy=0 cnt=2", tx_busy, udp_frame_cnt);
    end
  endtask

  task automatic test_coalesce();
    int ns;
    int nr;
    fifo_usedw = 11'd200;
    udp_en     = 1'b1;
    for (int i = 0; i < 10 && tx_start !== 1'b1; i++) step();
    udp_en = 1'b0;
    for (int p = 0; p < 3; p++) begin
      step();
      arp_op = 1'b1;
      step();
      arp_op = 1'b0;
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    run_frames(40, ns, nr);
    vectors++;
    if (ns != 1 || nr != 1) begin
      miscompares++;
      $display("FAIL t5_coalesce: got %0d starts %0d replies, want 1 and 1", ns, nr);
    end
    vectors++;
    if (udp_frame_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL t5_udp_count: got %0d, want 3", udp_frame_cnt);
    end
    // Second arp_op lands on the grant edge and must survive the clear.
    arp_op = 1'b1;
    step();
    step();
    arp_op = 1'b0;
    vectors++;
    if (tx_start !== 1'b1 || tx_sel !== 2'b01) begin
      miscompares++;
      $display("FAIL t5_grant_reply: got start=%b sel=%b, want start=1 sel=01", tx_start, tx_sel);
    end
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    run_frames(40, ns, nr);
    vectors++;
    if (ns != 1 || nr != 1) begin
      miscompares++;
      $display("FAIL t5_set_wins: got %0d starts %0d replies, want 1 and 1", ns, nr);
    end
  endtask

  task automatic test_reset_mid_frame();
    int ns;
    int nr;
    fifo_usedw = 11'd200;
    udp_en     = 1'b1;
    for (int i = 0; i < 10 && tx_start !== 1'b1; i++) step();
    udp_en = 1'b0;
    step();
    step();
    vectors++;
    if (tx_busy !== 1'b1 || tx_sel !== 2'b11) begin
      miscompares++;
      $display("FAIL t6_in_wait: got busy=%b sel=%b, want busy=1 sel=11", tx_busy, tx_sel);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({tx_busy, tx_sel, tx_start, tx_timeout} !== 5'd0 || udp_frame_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL t6_async_reset: got busy=%b sel=%b start=%b to=%b cnt=%0d, want all 0",
               tx_busy, tx_sel, tx_start, tx_timeout, udp_frame_cnt);
    end
    step();
    step();
    arp_resolved = 1'b1;
    fifo_usedw   = '0;
    udp_en       = 1'b1;
    rst_n        = 1'b1;
    run_frames(30, ns, nr);
    vectors++;
    if (ns != 0 || tx_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL t6_quiet: got %0d starts timeout=%b, want 0 starts timeout=0",
               ns, tx_timeout);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    test_reset();
    test_arp_request();
    test_reply_then_udp();
    test_udp_threshold();
    test_timeout();
    test_coalesce();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1 ms, want finished");
    $fatal(1);
  end

endmodule
